// File: rtl/arb_pkg.sv
// Shared types, sizes and helpers for the round-robin grant scheduler.
package arb_pkg;

  localparam int unsigned N_REQ            = 8;
  localparam int unsigned IDX_W            = 3;
  localparam int unsigned HOLD_MAX_DEFAULT = 15;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  // Bit i of the result is v[(i + sh) mod N_REQ], so bit 0 is the current priority holder.
  function automatic logic [N_REQ-1:0] rotate_right(input logic [N_REQ-1:0] v,
                                                    input logic [IDX_W-1:0] sh);
    logic [N_REQ-1:0] r;
    logic [IDX_W-1:0] k;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k    = IDX_W'(i) + sh;
      r[i] = v[k];
    end
    return r;
  endfunction

  // Index of the lowest set bit; 0 when v is empty.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_decoder_3to8.sv
// Index to one-hot expander, forced to zero when not enabled.
module decoder_3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter: one grant at a time, released by done, owner withdrawal or hold timeout.
module rr_grant_scheduler
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o,
  output logic             timeout_o
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] rot_req;
  logic [IDX_W-1:0] winner;
  logic             expire;
  logic             owner_req;

  // Search starts at ptr: rotate so ptr lands on bit 0, encode, then undo the rotation.
  always_comb begin
    rot_req = rotate_right(req_i, ptr_q);
    winner  = prio_enc(rot_req) + ptr_q;
  end

  assign owner_req = req_i[idx_q];
  assign expire    = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          idx_d   = winner;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = (cnt_q == CNT_W'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
        if (done_i || !owner_req || expire) begin
          state_d   = StIdle;
          ptr_d     = idx_q + 1'b1;
          // Timer only gets the blame when no voluntary release happened on the same edge.
          timeout_d = expire && !done_i && owner_req;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid_o = (state_q == StBusy);
  assign grant_idx_o   = idx_q;
  assign timeout_o     = timeout_q;

  decoder_3to8 u_decoder (
    .idx_i    (idx_q),
    .en_i     (grant_valid_o),
    .onehot_o (grant_o)
  );

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with a short hold timeout.
module tb_rr_grant_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_grant_scheduler #(
    .HOLD_MAX (4),
    .CNT_W    (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .done_i        (done),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .timeout_o     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_grant", grant, 8'h00);
    chk("rst_valid", grant_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_idx", grant_idx, 3'd0);

    // Single requester, then release moves ptr to 4.
    req = 8'h08;
    tick();
    chk("single_grant", grant, 8'h08);
    chk("single_idx", grant_idx, 3'd3);
    chk("single_valid", grant_valid, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_rel_grant", grant, 8'h00);
    chk("single_rel_valid", grant_valid, 1'b0);
    req = 8'hFF;
    tick();
    chk("ptr4_idx", grant_idx, 3'd4);
    chk("ptr4_grant", grant, 8'h10);

    // Asynchronous reset mid-BUSY, released off the clock edge.
    #3 rst = 1'b1;
    #1;
    chk("async_grant", grant, 8'h00);
    chk("async_valid", grant_valid, 1'b0);
    chk("async_timeout", timeout, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk("ptr0_idx", grant_idx, 3'd0);

    // Full rotation with everyone requesting.
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] exp_oh;
      exp_oh = 8'h01 << (k % 8);
      chk("rot_idx", grant_idx, 32'(k % 8));
      chk("rot_grant", grant, exp_oh);
      tick();
      chk("rot_hold", grant, exp_oh);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("rot_gap", grant, 8'h00);
      if (k != 8) tick();
    end

    // Idle now with ptr=1; sole requester 5 runs into the hold timer.
    req = 8'h20;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_idx", grant_idx, 3'd5);
      chk("to_valid", grant_valid, 1'b1);
      chk("to_early", timeout, 1'b0);
      tick();
    end
    chk("to_rel_valid", grant_valid, 1'b0);
    chk("to_pulse", timeout, 1'b1);
    chk("to_rel_grant", grant, 8'h00);
    tick();
    chk("to_regrant", grant_idx, 3'd5);
    chk("to_regrant_v", grant_valid, 1'b1);
    chk("to_pulse_end", timeout, 1'b0);

    // Wrap: owner 5 withdraws, 6 served, then ptr=7.
    req = 8'h40;
    tick();
    chk("wd5_valid", grant_valid, 1'b0);
    tick();
    chk("own6_idx", grant_idx, 3'd6);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h81;
    tick();
    chk("wrap7_idx", grant_idx, 3'd7);
    chk("wrap7_grant", grant, 8'h80);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("wrap0_idx", grant_idx, 3'd0);

    // done on the same edge as timer expiry: plain release.
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("dx_valid", grant_valid, 1'b0);
    chk("dx_timeout", timeout, 1'b0);

    // ptr=1: owner 7, which then withdraws.
    tick();
    chk("own7_idx", grant_idx, 3'd7);
    req = 8'h01;
    tick();
    chk("drop_valid", grant_valid, 1'b0);
    chk("drop_timeout", timeout, 1'b0);

    // done while idle must not disturb ptr=0.
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_done_v", grant_valid, 1'b0);
    req = 8'h06;
    tick();
    chk("idle_done_idx", grant_idx, 3'd1);

    // done together with owner withdrawal: one release, stays idle.
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("both_valid", grant_valid, 1'b0);
    chk("both_timeout", timeout, 1'b0);
    tick();
    chk("both_idle", grant_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
